hyperbus_cfg_seq: RTL and testbench

- Boot-time register-bus master that programs the HyperBus controller's configuration registers from a table of (address, data) pairs.
- Sits between the SoC reset/boot logic and the HyperBus regbus slave port.
- Issues each write in order and reports done or error.
- Holds off AXI traffic to the controller (via axi_hold_o) until configuration completes.

---
 rtl/hyperbus_cfg_seq_pkg.sv | 17 +
 rtl/hyperbus_cfg_seq_timeout.sv | 33 +++
 rtl/hyperbus_cfg_seq.sv | 149 ++++++++++++++
 tb/tb_hyperbus_cfg_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_cfg_seq_pkg.sv
// Shared types and helpers for the HyperBus boot-time configuration sequencer.
package hyperbus_cfg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hyperbus_cfg_seq_timeout.sv
// Per-access stall counter. Expired pulses in the stall cycle in which the
// count reaches TimeoutCycles; TimeoutCycles = 0 never expires.
module hyperbus_cfg_seq_timeout
  import hyperbus_cfg_seq_pkg::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntWidth = clog2_min1(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] Limit = CntWidth'(TimeoutCycles);

  logic [CntWidth-1:0] count;

  // Count stall cycles of the current access, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != Limit)) begin
      count <= count + CntWidth'(1);
    end
  end

  assign expired = (TimeoutCycles != 0) && enable && (count == Limit - CntWidth'(1));

endmodule

// File: rtl/hyperbus_cfg_seq.sv
// Boot-time regbus master that writes an (address, data) table into the
// HyperBus controller and holds AXI off until it succeeds.
// Optional readback check of every write: define HYPERBUS_CFG_SEQ_VERIFY_EN.
module hyperbus_cfg_seq
  import hyperbus_cfg_seq_pkg::*;
#(
  parameter int NumEntries    = 4,
  parameter int RegAddrWidth  = 32,
  parameter int RegDataWidth  = 32,
  parameter int TimeoutCycles = 1024,
  localparam int IdxWidth     = clog2_min1(NumEntries)
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_sys_ni,
  input  logic                               start_i,
  input  logic [NumEntries*RegAddrWidth-1:0] cfg_addr_i,
  input  logic [NumEntries*RegDataWidth-1:0] cfg_data_i,
  output logic [RegAddrWidth-1:0]            rbus_req_addr_o,
  output logic                               rbus_req_write_o,
  output logic [RegDataWidth-1:0]            rbus_req_wdata_o,
  output logic [RegDataWidth/8-1:0]          rbus_req_wstrb_o,
  output logic                               rbus_req_valid_o,
  input  logic [RegDataWidth-1:0]            rbus_rsp_rdata_i,
  input  logic                               rbus_rsp_ready_i,
  input  logic                               rbus_rsp_error_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic [IdxWidth-1:0]                err_idx_o,
  output logic                               axi_hold_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumEntries - 1);

  state_e                  state, next_state;
  logic [IdxWidth-1:0]     idx, err_idx;
  logic                    req_valid, req_write;
  logic                    idx_clr, idx_inc;
  logic                    expired;
  logic [RegAddrWidth-1:0] cur_addr;
  logic [RegDataWidth-1:0] cur_data;

  assign cur_addr = cfg_addr_i[idx*RegAddrWidth +: RegAddrWidth];
  assign cur_data = cfg_data_i[idx*RegDataWidth +: RegDataWidth];

  // A new access starts whenever the previous one completes or valid is low.
  hyperbus_cfg_seq_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk    (clk_sys_i),
    .rst_n  (rst_sys_ni),
    .clear  (!req_valid || rbus_rsp_ready_i),
    .enable (req_valid && !rbus_rsp_ready_i),
    .expired(expired)
  );

`ifndef HYPERBUS_CFG_SEQ_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^rbus_rsp_rdata_i;
`endif

  // State, entry index and failing-index registers.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state   <= ST_IDLE;
      idx     <= '0;
      err_idx <= '0;
    end else begin
      state <= next_state;
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + IdxWidth'(1);
      end
      if ((state != ST_FAIL) && (next_state == ST_FAIL)) begin
        err_idx <= idx;
      end
    end
  end

  // Next-state logic and regbus request control.
  always_comb begin
    next_state = state;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_i) begin
          next_state = ST_WRITE;
          idx_clr    = 1'b1;
        end
      end
      ST_WRITE: begin
        req_valid = 1'b1;
        req_write = 1'b1;
        if (rbus_rsp_ready_i) begin
          if (rbus_rsp_error_i) begin
            next_state = ST_FAIL;
          end else begin
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
            next_state = ST_VERIFY;
`else
            if (idx == LastIdx) begin
              next_state = ST_DONE;
            end else begin
              idx_inc = 1'b1;
            end
`endif
          end
        end else if (expired) begin
          next_state = ST_FAIL;
        end
      end
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
      ST_VERIFY: begin
        req_valid = 1'b1;
        if (rbus_rsp_ready_i) begin
          if (rbus_rsp_error_i || (rbus_rsp_rdata_i != cur_data)) begin
            next_state = ST_FAIL;
          end else if (idx == LastIdx) begin
            next_state = ST_DONE;
          end else begin
            idx_inc    = 1'b1;
            next_state = ST_WRITE;
          end
        end else if (expired) begin
          next_state = ST_FAIL;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  assign rbus_req_valid_o = req_valid;
  assign rbus_req_write_o = req_write;
  assign rbus_req_addr_o  = req_valid ? cur_addr : '0;
  assign rbus_req_wdata_o = req_write ? cur_data : '0;
  assign rbus_req_wstrb_o = req_write ? '1 : '0;

  assign busy_o     = (state == ST_WRITE) || (state == ST_VERIFY);
  assign done_o     = (state == ST_DONE);
  assign error_o    = (state == ST_FAIL);
  assign err_idx_o  = err_idx;
  assign axi_hold_o = (state != ST_DONE);

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Directed testbench for hyperbus_cfg_seq (NumEntries=4, TimeoutCycles=8).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_hyperbus_cfg_seq;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [N*AW-1:0] cfg_addr;
  logic [N*DW-1:0] cfg_data;
  logic [AW-1:0]   req_addr;
  logic            req_write;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            req_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_ready;
  logic            rsp_error;
  logic            busy;
  logic            done;
  logic            error;
  logic [1:0]      err_idx;
  logic            axi_hold;

  logic [AW-1:0] addr_tab [N];
  logic [DW-1:0] data_tab [N];

  int vectors     = 0;
  int miscompares = 0;

  hyperbus_cfg_seq #(
    .NumEntries   (N),
    .RegAddrWidth (AW),
    .RegDataWidth (DW),
    .TimeoutCycles(8)
  ) dut (
    .clk_sys_i       (clk),
    .rst_sys_ni      (rst_n),
    .start_i         (start),
    .cfg_addr_i      (cfg_addr),
    .cfg_data_i      (cfg_data),
    .rbus_req_addr_o (req_addr),
    .rbus_req_write_o(req_write),
    .rbus_req_wdata_o(req_wdata),
    .rbus_req_wstrb_o(req_wstrb),
    .rbus_req_valid_o(req_valid),
    .rbus_rsp_rdata_i(rsp_rdata),
    .rbus_rsp_ready_i(rsp_ready),
    .rbus_rsp_error_i(rsp_error),
    .busy_o          (busy),
    .done_o          (done),
    .error_o         (error),
    .err_idx_o       (err_idx),
    .axi_hold_o      (axi_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One-cycle start pulse, issued from a falling edge; returns in cycle 1.
  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expect an access to entry k in the current cycle.
  task automatic checkAccess(input string tag, input int k, input bit is_write);
    checkOutput({tag, " valid"}, 64'(req_valid), 64'(1));
    checkOutput({tag, " addr"},  64'(req_addr),  64'(addr_tab[k]));
    checkOutput({tag, " write"}, 64'(req_write), 64'(is_write));
    checkOutput({tag, " wstrb"}, 64'(req_wstrb), is_write ? 64'hF : 64'h0);
    if (is_write) checkOutput({tag, " wdata"}, 64'(req_wdata), 64'(data_tab[k]));
    checkOutput({tag, " busy"},  64'(busy),      64'(1));
    checkOutput({tag, " hold"},  64'(axi_hold),  64'(1));
  endtask

  // Expect the sequencer idle-like status outputs.
  task automatic checkStatus(input string tag, input bit exp_busy, input bit exp_done,
                             input bit exp_error, input logic [1:0] exp_idx, input bit exp_hold);
    checkOutput({tag, " valid"},   64'(req_valid), 64'(exp_busy));
    checkOutput({tag, " busy"},    64'(busy),      64'(exp_busy));
    checkOutput({tag, " done"},    64'(done),      64'(exp_done));
    checkOutput({tag, " error"},   64'(error),     64'(exp_error));
    checkOutput({tag, " err_idx"}, 64'(err_idx),   64'(exp_idx));
    checkOutput({tag, " hold"},    64'(axi_hold),  64'(exp_hold));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      addr_tab[k] = 32'h1000_0000 + 32'(k * 4);
      data_tab[k] = 32'hA5A5_0000 + 32'(k);
    end
    data_tab[3] = 32'h0000_0001;
    for (int k = 0; k < N; k++) begin
      cfg_addr[k*AW +: AW] = addr_tab[k];
      cfg_data[k*DW +: DW] = data_tab[k];
    end
    rst_n     = 1'b0;
    start     = 1'b0;
    rsp_ready = 1'b0;
    rsp_error = 1'b0;
    rsp_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkStatus("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput("reset addr",  64'(req_addr),  64'h0);
    checkOutput("reset wdata", 64'(req_wdata), 64'h0);
    checkOutput("reset wstrb", 64'(req_wstrb), 64'h0);
    checkOutput("reset write", 64'(req_write), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef HYPERBUS_CFG_SEQ_VERIFY_EN
    // Ready tied high: four back-to-back writes, done at cycle 5.
    rsp_ready = 1'b1;
    applyStimulus();
    for (int k = 0; k < N; k++) begin
      checkAccess($sformatf("burst c%0d", k + 1), k, 1'b1);
      @(negedge clk);
    end
    checkStatus("burst c5", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

    // Slave stalls entry 2 by three cycles; request must hold steady.
    applyStimulus();
    checkOutput("stall c1 done cleared", 64'(done), 64'(0));
    checkAccess("stall c1", 0, 1'b1);
    @(negedge clk);
    checkAccess("stall c2", 1, 1'b1);
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      checkAccess($sformatf("stall c%0d", w + 3), 2, 1'b1);
      rsp_ready = (w == 3);
      @(negedge clk);
    end
    checkAccess("stall c7", 3, 1'b1);
    @(negedge clk);
    checkStatus("stall c8", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

    // Slave error on entry 1: abort, entry 2 never accessed.
    applyStimulus();
    checkAccess("err c1", 0, 1'b1);
    @(negedge clk);
    checkAccess("err c2", 1, 1'b1);
    rsp_error = 1'b1;
    @(negedge clk);
    rsp_error = 1'b0;
    checkStatus("err c3", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("err idle%0d valid", c), 64'(req_valid), 64'(0));
    end

    // Ready never comes: eight stall cycles, then FAIL on entry 0.
    rsp_ready = 1'b0;
    applyStimulus();
    checkOutput("tmo c1 error cleared", 64'(error), 64'(0));
    for (int c = 1; c <= 8; c++) begin
      checkAccess($sformatf("tmo c%0d", c), 0, 1'b1);
      @(negedge clk);
    end
    checkStatus("tmo c9", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);

    // Extra start while busy is ignored; reset mid-access clears everything.
    rsp_ready = 1'b1;
    applyStimulus();
    checkAccess("rst c1", 0, 1'b1);
    @(negedge clk);
    checkAccess("rst c2", 1, 1'b1);
    rsp_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkAccess("rst c3 start ignored", 1, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkAccess("rst c4", 2, 1'b1);
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkStatus("rst async", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkStatus("rst released", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
`else
    // Readback enabled: write/read interleave, entry 3 reads back wrong data.
    rsp_ready = 1'b1;
    applyStimulus();
    for (int k = 0; k < N; k++) begin
      checkAccess($sformatf("vfy w%0d", k), k, 1'b1);
      @(negedge clk);
      checkAccess($sformatf("vfy r%0d", k), k, 1'b0);
      rsp_rdata = (k == 3) ? 32'hDEAD_BEEF : data_tab[k];
      @(negedge clk);
    end
    checkStatus("vfy end", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
